// File: rtl/servo_pkg.sv
// Shared servo constants: timebase, frame length, named arm/gripper positions
// and the decoder state encoding.
package servo_pkg;

  localparam int unsigned CLK_PER_MS = 50000;
  localparam int unsigned CW         = 21;
  localparam int unsigned FRAME_LEN  = 1000000;

  // High-times in clock cycles for the named servo positions.
  localparam int unsigned POS_ARM_DOWN     = 118000;
  localparam int unsigned POS_ARM_UP       = 135000;
  localparam int unsigned POS_GRIP_CLOSE   = 15000;
  localparam int unsigned POS_GRIP_DEFAULT = 65000;
  localparam int unsigned POS_GRIP_OPEN    = 115000;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } dec_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer plus history flop for an asynchronous PWM line;
// provides the synchronized level and single-cycle rise/fall strobes.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    level = s2;
    rise  = s2 & ~s3;
    fall  = ~s2 & s3;
  end

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures servo PWM high-time and rise-to-rise period in clock cycles and
// publishes one range-checked sample per completed period.
module servo_pwm_decoder #(
  parameter int unsigned CLK_PER_MS = 50000,
  parameter int unsigned CW         = 21,
  parameter int unsigned MIN_WIDTH  = CLK_PER_MS / 5,
  parameter int unsigned MAX_WIDTH  = 3 * CLK_PER_MS,
  parameter int unsigned MIN_PERIOD = 10 * CLK_PER_MS,
  parameter int unsigned PERIOD_MAX = 24 * CLK_PER_MS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  output logic [CW-1:0] width_out,
  output logic [CW-1:0] period_out,
  output logic          sample_valid,
  output logic          width_err,
  output logic          period_err,
  output logic          signal_lost
);

  import servo_pkg::*;

  localparam logic [CW-1:0] One  = CW'(1);
  localparam logic [CW-1:0] MinW = CW'(MIN_WIDTH);
  localparam logic [CW-1:0] MaxW = CW'(MAX_WIDTH);
  localparam logic [CW-1:0] MinP = CW'(MIN_PERIOD);
  localparam logic [CW-1:0] PMax = CW'(PERIOD_MAX);

  logic          level, rise, fall;
  dec_state_e    state;
  logic [CW-1:0] width_cnt, period_cnt;

  pwm_edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm_in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      width_cnt    <= '0;
      period_cnt   <= '0;
      width_out    <= '0;
      period_out   <= '0;
      sample_valid <= 1'b0;
      width_err    <= 1'b0;
      period_err   <= 1'b0;
      signal_lost  <= 1'b1;
    end else begin
      sample_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (rise) begin
            state      <= StHigh;
            width_cnt  <= One;
            period_cnt <= One;
          end
        end
        StHigh: begin
          // A fall at the limit cannot be followed by an in-range rise, so it times out too.
          if (period_cnt == PMax) begin
            state       <= StIdle;
            width_cnt   <= '0;
            period_cnt  <= '0;
            signal_lost <= 1'b1;
          end else if (fall) begin
            state      <= StLow;
            period_cnt <= period_cnt + One;
          end else begin
            width_cnt  <= width_cnt + CW'(level);
            period_cnt <= period_cnt + One;
          end
        end
        StLow: begin
          // Rise takes priority over timeout when both land on the same cycle.
          if (rise) begin
            width_out    <= width_cnt;
            period_out   <= period_cnt;
            width_err    <= (width_cnt < MinW) || (width_cnt > MaxW);
            period_err   <= period_cnt < MinP;
            sample_valid <= 1'b1;
            signal_lost  <= 1'b0;
            state        <= StHigh;
            width_cnt    <= One;
            period_cnt   <= One;
          end else if (period_cnt == PMax) begin
            state       <= StIdle;
            width_cnt   <= '0;
            period_cnt  <= '0;
            signal_lost <= 1'b1;
          end else begin
            period_cnt <= period_cnt + One;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
